// File: rtl/accum_unit.sv
// accum_unit: signed run accumulator fed by a valid/ready operand stream.
// Define SATURATE_EN to clamp on overflow instead of two's complement wrap.
module accum_unit #(
    parameter int WIDTH    = 5,
    parameter int IN_WIDTH = 5,
    parameter int COUNT    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                op_sub,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                in_ready,
    output logic [WIDTH-1:0]    result,
    output logic                gt_zero,
    output logic                ovf,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH:0]    op_ext;
    logic [WIDTH:0]    acc_ext;
    logic [WIDTH:0]    sum;
    logic              sum_ovf;
    logic [WIDTH-1:0]  sum_fix;
    logic              xfer;

    // One guard bit above WIDTH exposes overflow as a mismatch of the top two bits.
    assign op_ext  = {{(WIDTH + 1 - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign acc_ext = {result_q[WIDTH-1], result_q};
    assign sum     = op_sub ? (acc_ext - op_ext) : (acc_ext + op_ext);
    assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];

`ifdef SATURATE_EN
    // The guard bit carries the true sign, so it picks the clamp direction.
    always_comb begin
        sum_fix = sum[WIDTH-1:0];
        if (sum_ovf) begin
            sum_fix = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_fix = sum[WIDTH-1:0];
`endif

    assign xfer = (state_q == ACC) && in_valid;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACC;
                    count_d  = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            ACC: begin
                if (xfer) begin
                    result_d = sum_fix;
                    ovf_d    = ovf_q | sum_ovf;
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready = (state_q == ACC);
    assign busy     = (state_q == ACC);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign ovf      = ovf_q;
    assign gt_zero  = (result_q != '0) && !result_q[WIDTH-1];

endmodule

// File: tb/tb_accum_unit.sv
// tb_accum_unit: directed scenarios plus randomized traffic for accum_unit,
// checked every cycle against an integer-arithmetic reference model.
module tb_accum_unit;

    localparam int WIDTH    = 5;
    localparam int IN_WIDTH = 5;
    localparam int COUNT    = 4;
    localparam int MAXV     = (1 << (WIDTH - 1)) - 1;
    localparam int MINV     = -(1 << (WIDTH - 1));
    localparam int MODV     = 1 << WIDTH;
`ifdef SATURATE_EN
    localparam int OVF_RUN_RESULT = 15;
`else
    localparam int OVF_RUN_RESULT = 0;
`endif

    logic                clk      = 1'b0;
    logic                reset    = 1'b1;
    logic                start    = 1'b0;
    logic                op_sub   = 1'b0;
    logic                in_valid = 1'b0;
    logic [IN_WIDTH-1:0] in_data  = '0;
    logic                in_ready;
    logic [WIDTH-1:0]    result;
    logic                gt_zero;
    logic                ovf;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model: exact integer total, folded back into WIDTH-bit range.
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_ovf   = 1'b0;
    int m_total = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    accum_unit #(
        .WIDTH(WIDTH),
        .IN_WIDTH(IN_WIDTH),
        .COUNT(COUNT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op_sub(op_sub),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .result(result),
        .gt_zero(gt_zero),
        .ovf(ovf),
        .busy(busy),
        .done(done)
    );

    function automatic int exact_next(input int total, input bit sub, input logic [IN_WIDTH-1:0] d);
        int v;
        v = int'($signed(d));
        return sub ? (total - v) : (total + v);
    endfunction

    function automatic int fold(input int exact);
        int w;
`ifdef SATURATE_EN
        if (exact > MAXV) return MAXV;
        if (exact < MINV) return MINV;
        return exact;
`else
        w = (exact - MINV) % MODV;
        if (w < 0) w = w + MODV;
        return w + MINV;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_ovf   <= 1'b0;
            m_total <= 0;
            m_cnt   <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  <= 1'b1;
                m_total <= 0;
                m_ovf   <= 1'b0;
                m_cnt   <= 0;
            end
        end else if (in_valid) begin
            m_total <= fold(exact_next(m_total, op_sub, in_data));
            if (exact_next(m_total, op_sub, in_data) > MAXV ||
                exact_next(m_total, op_sub, in_data) < MINV) begin
                m_ovf <= 1'b1;
            end
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == COUNT) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Every cycle, all outputs must agree with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cyc_result",   int'(result),   int'(m_total[WIDTH-1:0]));
            checkOutput("cyc_gt_zero",  int'(gt_zero),  (m_total > 0) ? 1 : 0);
            checkOutput("cyc_ovf",      int'(ovf),      int'(m_ovf));
            checkOutput("cyc_busy",     int'(busy),     int'(m_busy));
            checkOutput("cyc_in_ready", int'(in_ready), int'(m_busy));
            checkOutput("cyc_done",     int'(done),     int'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic applyStimulus(input bit sub, input int data);
        op_sub   = sub;
        in_data  = data[IN_WIDTH-1:0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_sub   = 1'b0;
    endtask

    task automatic checkRunEnd(input string tag, input int res_bits, input int gz, input int ov);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, int'(done), 1);
        checkOutput({tag, "_result"}, int'(result), res_bits);
        checkOutput({tag, "_model"}, int'(m_total[WIDTH-1:0]), res_bits);
        checkOutput({tag, "_gt_zero"}, int'(gt_zero), gz);
        checkOutput({tag, "_ovf"}, int'(ovf), ov);
        tick();
        @(negedge clk);
        checkOutput({tag, "_done_low"}, int'(done), 0);
        checkOutput({tag, "_result_hold"}, int'(result), res_bits);
        tick();
    endtask

    initial begin
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state and quiet idle after release
        @(negedge clk);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_ovf", int'(ovf), 0);
        #6;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_result", int'(result), 0);
        checkOutput("idle_in_ready", int'(in_ready), 0);
        tick();

        // Add 3,4,2,5 back-to-back
        startRun();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b0, 5);
        checkRunEnd("add14", 14, 1, 0);

        // Subtract 1 four times
        startRun();
        repeat (4) applyStimulus(1'b1, 1);
        checkRunEnd("sub4", 28, 0, 0);

        // Overflowing run of 8s
        startRun();
        repeat (4) applyStimulus(1'b0, 8);
        checkRunEnd("ovf8", OVF_RUN_RESULT, (OVF_RUN_RESULT > 0) ? 1 : 0, 1);

        // Gapped valid with an ignored start pulse mid-run
        startRun();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, i);
            if (i < 4) begin
                start = (i == 2);
                tick();
                start = 1'b0;
            end
        end
        checkRunEnd("gap10", 10, 1, 0);

        // Abort mid-run with reset
        startRun();
        applyStimulus(1'b0, 5);
        applyStimulus(1'b0, 5);
        reset = 1'b0;
        #1;
        checkOutput("abort_result", int'(result), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_in_ready", int'(in_ready), 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", int'(done), 0);
        end
        tick();
        startRun();
        applyStimulus(1'b0, 1);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b0, 31);
        checkRunEnd("after_abort", 5, 1, 0);

        // Randomized traffic, including in_valid/start outside ACC and rare resets
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(0, 5) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            op_sub   = $urandom_range(0, 1);
            in_data  = IN_WIDTH'($urandom);
            reset    = ($urandom_range(0, 149) != 0);
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
